prio_req_arbiter: RTL and testbench
===================================

// Module: prio_req_arbiter
// PURPOSE
//   Parametrised, registered successor to the 8:3 combinational priority encoder.
//   Captures N request lines into sticky pending bits and applies a per-line mask.
//   Issues one grant at a time over a valid/ready handshake, in fixed-priority or
//   round-robin mode. Sits between interrupt/request sources and a single consumer.
// PARAMETERS
//   N   8   number of request lines (>=2)
//   W   $clog2(N)   localparam, width of grant index
// PORTS
//   clk             in   1  single clock, rising edge
//   rst_n           in   1  asynchronous reset, active low
//   req_i           in   N  request pulses/levels; bit k high sets pending[k]
//   mask_i          in   N  1 = line k ineligible; pending bit is kept
//   mode_i          in   1  0 = fixed (highest index wins), 1 = round-robin
//   grant_ready_i   in   1  consumer accepts current grant
//   grant_valid_o   out  1  grant_idx_o/grant_onehot_o are valid
//   grant_idx_o     out  W  index of granted line
//   grant_onehot_o  out  N  one-hot of grant_idx_o; 0 when grant_valid_o=0
//   none_o          out  1  no eligible pending line: (pending & ~mask_i)==0
//   pending_o       out  N  current pending register
// BEHAVIOUR
//   Reset (async, rst_n=0): pending=0, grant_valid_o=0, grant_idx_o=0,
//     grant_onehot_o=0, rr_ptr=N-1, state=IDLE; none_o=1 as a consequence.
//   pending[k] next = (pending[k] & ~clr[k]) | req_i[k]. clr[k] = handshake on k.
//     A req_i[k] in the same cycle as the handshake on k keeps pending[k] set.
//   eligible = pending & ~mask_i (registered pending, current mask).
//   Selection (combinational, from eligible):
//     fixed: highest set index. round-robin: first set index scanning downward
//     from rr_ptr, wrapping N-1 after 0.
//   FSM, 2 states:
//     IDLE : eligible!=0 -> load winner into grant regs, valid=1, go GRANT.
//            Latency: req_i in cycle t -> grant_valid_o in cycle t+2.
//     GRANT: grant regs held stable while grant_ready_i=0. Later masking or
//            higher-priority arrivals do not revoke or change the grant.
//            On handshake (valid & ready): clear pending[idx]; rr_ptr=(idx-1) mod N.
//            The next winner comes from eligible with bit idx removed, plus req_i.
//            Next winner exists -> load it and stay GRANT (1 grant/cycle).
//            Otherwise valid=0, onehot=0, go IDLE. grant_idx_o keeps its last value.
//   rr_ptr only changes on a handshake. It is unused in fixed mode but still updated.
//   mode_i is sampled only at selection time; a change during GRANT does not
//     affect the held grant.
//   none_o is combinational from pending and mask_i. It may be 1 while
//     grant_valid_o=1 if the granted line was masked after the grant.
//   Reset during GRANT: grant withdrawn immediately, all pending lost.
// STRUCTURE
//   Shared package prio_arb_pkg: state enum {IDLE, GRANT}, mode enum
//     {MODE_FIXED, MODE_RR}, function clog2 for W.
//   One sub-module: prio_rot_encoder (combinational). Inputs: vec[N], start[W].
//     Outputs: idx[W], found. Scans downward from start with wrap.
//     Fixed mode instantiates it with start=N-1.
//   Top holds the pending, grant, rr_ptr and state flops.
// TESTING (N=8)
//   1 Reset: assert rst_n=0 mid-run -> same cycle valid=0, onehot=0, pending_o=0,
//     none_o=1; after release no grant without new req_i.
//   2 Fixed, ready=1: req_i=8'h29 for 1 cycle -> grants idx 5,3,0 on three
//     consecutive cycles starting t+2; then valid=0, none_o=1.
//   3 RR, ready=1: req_i=8'h81 held -> grant sequence 7,0,7,0...
//     Fixed mode with the same stimulus -> 7,7,7...
//   4 Backpressure: grant idx 2 valid, ready=0 for 4 cycles, req_i[6] pulsed ->
//     idx stays 2, pending_o=8'h44. Then ready=1 -> next grant idx 6.
//   5 Mask: pending 8'h82, mask_i=8'h80 -> grant idx 1. Then mask_i=0 -> idx 7.
//     Masking a line while it is granted does not drop the grant.
//   6 Same-cycle re-request: handshake on idx 4 with req_i[4]=1 -> pending[4]
//     stays 1; with ready=1, RR mode -> next grant is 4 again only if no other
//     line is eligible.

Source files
------------

// File: rtl/prio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : prio_arb_pkg
// Brief  : Shared types and helpers for the registered priority arbiter.
// Rev    : 1.0
// ============================================================================
package prio_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : prio_req_arbiter_if
// Brief  : Grant valid/ready channel between the arbiter and its consumer.
// Rev    : 1.0
// ============================================================================
interface prio_req_arbiter_if #(
    parameter int N = 8
);
    localparam int W = prio_arb_pkg::clog2(N);

    logic         grant_valid_o;
    logic         grant_ready_i;
    logic [W-1:0] grant_idx_o;
    logic [N-1:0] grant_onehot_o;

    modport master (
        output grant_valid_o,
        output grant_idx_o,
        output grant_onehot_o,
        input  grant_ready_i
    );

    modport slave (
        input  grant_valid_o,
        input  grant_idx_o,
        input  grant_onehot_o,
        output grant_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/prio_rot_encoder.sv
`default_nettype none
// ============================================================================
// Module : prio_rot_encoder
// Brief  : Finds the first set bit scanning downward from start, wrapping.
// Rev    : 1.0
// ============================================================================
module prio_rot_encoder
    import prio_arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin : comb_scan
        int           p;
        logic [W-1:0] p_w;
        p     = 0;
        p_w   = '0;
        idx   = '0;
        found = |vec;
        // Walk from the farthest position back to start so the nearest hit wins.
        for (int i = N - 1; i >= 0; i--) begin
            p = int'(start) - i;
            if (p < 0) p = p + N;
            p_w = W'(p);
            if (vec[p_w]) idx = p_w;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prio_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : prio_req_arbiter
// Brief  : Sticky request capture with masked fixed/round-robin grant issue.
// Rev    : 1.0
// ============================================================================
module prio_req_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              req_i,
    input  logic [N-1:0]              mask_i,
    input  logic                      mode_i,
    prio_req_arbiter_if.master        arb_if,
    output logic                      none_o,
    output logic [N-1:0]              pending_o
);

    localparam int           W    = clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    state_e       state_q,   state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] rr_ptr_q,  rr_ptr_d;
    logic         valid_q,   valid_d;
    logic [W-1:0] idx_q,     idx_d;
    logic [N-1:0] onehot_q,  onehot_d;

    logic [N-1:0] eligible, clr, sel_vec, sel_oh;
    logic [W-1:0] sel_start, sel_idx, ptr_dec;
    logic         handshake, sel_found;

    prio_rot_encoder #(.N(N)) u_enc (
        .vec   (sel_vec),
        .start (sel_start),
        .idx   (sel_idx),
        .found (sel_found)
    );

    always_comb begin
        eligible  = pending_q & ~mask_i;
        handshake = (state_q == GRANT) && valid_q && arb_if.grant_ready_i;
        clr       = '0;
        if (handshake) clr[idx_q] = 1'b1;
        pending_d = (pending_q & ~clr) | req_i;
        ptr_dec   = (idx_q == '0) ? LAST : idx_q - 1'b1;
        rr_ptr_d  = handshake ? ptr_dec : rr_ptr_q;
        // Back-to-back grants select from the post-handshake pending view.
        sel_vec   = handshake ? (pending_d & ~mask_i) : eligible;
        sel_start = (mode_e'(mode_i) == MODE_RR) ? rr_ptr_d : LAST;
        sel_oh    = '0;
        sel_oh[sel_idx] = 1'b1;

        state_d  = state_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d  = GRANT;
                    valid_d  = 1'b1;
                    idx_d    = sel_idx;
                    onehot_d = sel_oh;
                end
            end
            GRANT: begin
                if (handshake) begin
                    if (sel_found) begin
                        idx_d    = sel_idx;
                        onehot_d = sel_oh;
                    end else begin
                        state_d  = IDLE;
                        valid_d  = 1'b0;
                        onehot_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rr_ptr_q  <= LAST;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            onehot_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
        end
    end

    assign arb_if.grant_valid_o  = valid_q;
    assign arb_if.grant_idx_o    = idx_q;
    assign arb_if.grant_onehot_o = onehot_q;
    assign none_o                = ~|eligible;
    assign pending_o             = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_prio_req_arbiter
// Brief  : Directed-vector bench for prio_req_arbiter with N=8.
// Rev    : 1.0
// ============================================================================
module tb_prio_req_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic [7:0] mask_i;
    logic       mode_i;
    logic       none_o;
    logic [7:0] pending_o;

    int n_vec;
    int n_err;

    prio_req_arbiter_if #(.N(8)) arb_if ();

    prio_req_arbiter #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .mask_i    (mask_i),
        .mode_i    (mode_i),
        .arb_if    (arb_if),
        .none_o    (none_o),
        .pending_o (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = 8'h00;
        mask_i = 8'h00;
        arb_if.grant_ready_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_grant(input string tag, input logic v, input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'h00;
        if (v) oh[idx] = 1'b1;
        check({tag, ".valid"}, 32'(arb_if.grant_valid_o), 32'(v));
        check({tag, ".onehot"}, 32'(arb_if.grant_onehot_o), 32'(oh));
        if (v) check({tag, ".idx"}, 32'(arb_if.grant_idx_o), 32'(idx));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_i = 8'h00;
        mask_i = 8'h00;
        mode_i = 1'b0;
        arb_if.grant_ready_i = 1'b0;
        #3;
        check("rst.valid", 32'(arb_if.grant_valid_o), 32'd0);
        check("rst.idx", 32'(arb_if.grant_idx_o), 32'd0);
        check("rst.onehot", 32'(arb_if.grant_onehot_o), 32'd0);
        check("rst.pending", 32'(pending_o), 32'd0);
        check("rst.none", 32'(none_o), 32'd1);

        // Fixed priority, 8'h29 pulsed once -> 5, 3, 0 back to back
        do_reset();
        mode_i = 1'b0;
        arb_if.grant_ready_i = 1'b1;
        req_i = 8'h29;
        step(); req_i = 8'h00;
        chk_grant("fix.t1", 1'b0, 3'd0);
        check("fix.t1.pending", 32'(pending_o), 32'h29);
        step(); chk_grant("fix.t2", 1'b1, 3'd5);
        check("fix.t2.pending", 32'(pending_o), 32'h29);
        step(); chk_grant("fix.t3", 1'b1, 3'd3);
        check("fix.t3.pending", 32'(pending_o), 32'h09);
        step(); chk_grant("fix.t4", 1'b1, 3'd0);
        step(); chk_grant("fix.t5", 1'b0, 3'd0);
        check("fix.t5.idx_kept", 32'(arb_if.grant_idx_o), 32'd0);
        check("fix.t5.none", 32'(none_o), 32'd1);

        // Round-robin with 8'h81 held -> 7, 0, 7, 0
        do_reset();
        mode_i = 1'b1;
        arb_if.grant_ready_i = 1'b1;
        req_i = 8'h81;
        step(); step();
        chk_grant("rr.g0", 1'b1, 3'd7);
        step(); chk_grant("rr.g1", 1'b1, 3'd0);
        step(); chk_grant("rr.g2", 1'b1, 3'd7);
        step(); chk_grant("rr.g3", 1'b1, 3'd0);

        // Fixed with the same stimulus -> 7, 7, 7
        do_reset();
        mode_i = 1'b0;
        arb_if.grant_ready_i = 1'b1;
        req_i = 8'h81;
        step(); step();
        for (int k = 0; k < 3; k++) begin
            chk_grant($sformatf("fixhold.g%0d", k), 1'b1, 3'd7);
            step();
        end

        // Backpressure: grant 2 held while 6 arrives
        do_reset();
        mode_i = 1'b0;
        req_i = 8'h04;
        step(); req_i = 8'h00;
        step(); chk_grant("bp.t2", 1'b1, 3'd2);
        req_i = 8'h40;
        step(); req_i = 8'h00;
        for (int k = 3; k < 6; k++) begin
            chk_grant($sformatf("bp.t%0d", k), 1'b1, 3'd2);
            check($sformatf("bp.t%0d.pending", k), 32'(pending_o), 32'h44);
            step();
        end
        arb_if.grant_ready_i = 1'b1;
        step(); chk_grant("bp.next", 1'b1, 3'd6);
        check("bp.next.pending", 32'(pending_o), 32'h40);
        step(); chk_grant("bp.done", 1'b0, 3'd0);

        // Mask steers the grant; masking a granted line keeps it
        do_reset();
        mode_i = 1'b0;
        mask_i = 8'h80;
        req_i = 8'h82;
        step(); req_i = 8'h00;
        check("mask.none", 32'(none_o), 32'd0);
        step(); chk_grant("mask.g1", 1'b1, 3'd1);
        mask_i = 8'h00;
        arb_if.grant_ready_i = 1'b1;
        step(); chk_grant("mask.g7", 1'b1, 3'd7);
        arb_if.grant_ready_i = 1'b0;
        mask_i = 8'h80;
        #1;
        check("mask.none_while_granted", 32'(none_o), 32'd1);
        step(); chk_grant("mask.hold", 1'b1, 3'd7);
        mask_i = 8'h00;
        arb_if.grant_ready_i = 1'b1;
        step(); chk_grant("mask.done", 1'b0, 3'd0);

        // Same-cycle re-request in round-robin
        do_reset();
        mode_i = 1'b1;
        req_i = 8'h10;
        step(); req_i = 8'h00;
        step(); chk_grant("rereq.g4", 1'b1, 3'd4);
        arb_if.grant_ready_i = 1'b1;
        req_i = 8'h10;
        step(); chk_grant("rereq.again4", 1'b1, 3'd4);
        check("rereq.pending", 32'(pending_o), 32'h10);
        req_i = 8'h11;
        step(); chk_grant("rereq.other0", 1'b1, 3'd0);
        req_i = 8'h00;
        step(); chk_grant("rereq.back4", 1'b1, 3'd4);
        step(); chk_grant("rereq.done", 1'b0, 3'd0);

        // Asynchronous reset while a grant is outstanding
        do_reset();
        mode_i = 1'b0;
        req_i = 8'h0F;
        step(); req_i = 8'h00;
        step(); chk_grant("arst.pre", 1'b1, 3'd3);
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(arb_if.grant_valid_o), 32'd0);
        check("arst.onehot", 32'(arb_if.grant_onehot_o), 32'd0);
        check("arst.pending", 32'(pending_o), 32'd0);
        check("arst.none", 32'(none_o), 32'd1);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_grant($sformatf("arst.post%0d", k), 1'b0, 3'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
